// File: rtl/error_log_reader.sv
// Error-log consumer: DEPTH-entry FIFO of log beats with fill/fatal IRQ.
// Define ERR_LOG_OVERWRITE_EN to overwrite the oldest entry when full.
module error_log_reader #(
  parameter int          DEPTH      = 16,
  parameter int          IRQ_THRESH = 8,
  parameter logic [31:0] FATAL_MASK = 32'h000000AA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     error_log_valid,
  input  logic [63:0]              error_log_data,
  input  logic [31:0]              error_timestamp,
  output logic                     rd_valid,
  output logic [63:0]              rd_data,
  output logic [31:0]              rd_timestamp,
  output logic [4:0]               rd_type,
  input  logic                     rd_pop,
  input  logic                     log_clear,
  input  logic                     irq_ack,
  output logic [$clog2(DEPTH):0]   log_count,
  output logic                     log_full,
  output logic [15:0]              overflow_count,
  output logic                     fatal_pending,
  output logic                     log_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] THR = (AW+1)'(IRQ_THRESH);

  logic [63:0] r_data [DEPTH];
  logic [31:0] r_ts   [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [15:0] r_ovf;
  logic        r_fatal;

  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_rd_adv;
  logic        w_lost;
  logic [4:0]  w_type;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_type  = error_log_data[22:18];
  assign w_pop   = rd_pop & ~w_empty;
  assign w_lost  = error_log_valid & w_full & ~w_pop;

`ifdef ERR_LOG_OVERWRITE_EN
  // When full, a new beat pushes out the oldest entry.
  assign w_wr     = error_log_valid;
  assign w_rd_adv = w_pop | w_lost;
`else
  // When full, the new beat is dropped unless a pop frees a slot.
  assign w_wr     = error_log_valid & (~w_full | w_pop);
  assign w_rd_adv = w_pop;
`endif

  // Storage array; stale contents are masked by rd_valid on the outputs.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[r_wr_ptr[AW-1:0]] <= error_log_data;
      r_ts[r_wr_ptr[AW-1:0]]   <= error_timestamp;
    end
  end

  // Pointer update; clear and reset flush the FIFO and discard any push.
  always_ff @(posedge clk) begin
    if (rst || log_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Saturating count of entries lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst || log_clear) begin
      r_ovf <= '0;
    end else if (w_lost && r_ovf != 16'hFFFF) begin
      r_ovf <= r_ovf + 16'd1;
    end
  end

  // Sticky fatal flag: capture wins over ack, clear wins over both.
  always_ff @(posedge clk) begin
    if (rst || log_clear) begin
      r_fatal <= 1'b0;
    end else if (w_wr && FATAL_MASK[w_type]) begin
      r_fatal <= 1'b1;
    end else if (irq_ack) begin
      r_fatal <= 1'b0;
    end
  end

  // Head presentation, zeroed when empty.
  always_comb begin
    rd_valid     = ~w_empty;
    rd_data      = '0;
    rd_timestamp = '0;
    if (!w_empty) begin
      rd_data      = r_data[r_rd_ptr[AW-1:0]];
      rd_timestamp = r_ts[r_rd_ptr[AW-1:0]];
    end
    rd_type = rd_data[22:18];
  end

  assign log_count      = w_count;
  assign log_full       = w_full;
  assign overflow_count = r_ovf;
  assign fatal_pending  = r_fatal;
  assign log_irq        = (w_count >= THR) | r_fatal;

endmodule

// File: tb/tb_error_log_reader.sv
// Directed bench for error_log_reader: vector table plus
// hand sequences for fill/overflow, full push+pop, clear and reset.
module tb_error_log_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        error_log_valid;
  logic [63:0] error_log_data;
  logic [31:0] error_timestamp;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic [31:0] rd_timestamp;
  logic [4:0]  rd_type;
  logic        rd_pop;
  logic        log_clear;
  logic        irq_ack;
  logic [4:0]  log_count;
  logic        log_full;
  logic [15:0] overflow_count;
  logic        fatal_pending;
  logic        log_irq;

  int errors = 0;
  int checks = 0;

  error_log_reader dut (
    .clk(clk), .rst(rst),
    .error_log_valid(error_log_valid),
    .error_log_data(error_log_data),
    .error_timestamp(error_timestamp),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_timestamp(rd_timestamp), .rd_type(rd_type),
    .rd_pop(rd_pop), .log_clear(log_clear),
    .irq_ack(irq_ack), .log_count(log_count),
    .log_full(log_full),
    .overflow_count(overflow_count),
    .fatal_pending(fatal_pending),
    .log_irq(log_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  ty;
    logic [31:0] ts;
    logic        pop;
    logic        clr;
    logic        ack;
    logic        e_rv;
    logic [4:0]  e_ty;
    logic [31:0] e_ts;
    logic [4:0]  e_cnt;
    logic        e_irq;
    logic        e_fat;
    logic [15:0] e_ovf;
  } vec_t;

  vec_t tv [11];

  function automatic logic [63:0] mkd(
    input logic [4:0] ty, input logic [31:0] ts);
    return {ts, 9'h0, ty, 18'h15A5A};
  endfunction

  function automatic vec_t mk(
    input logic v, input logic [4:0] ty,
    input logic [31:0] ts, input logic pop,
    input logic clr, input logic ack,
    input logic e_rv, input logic [4:0] e_ty,
    input logic [31:0] e_ts, input logic [4:0] e_cnt,
    input logic e_irq, input logic e_fat,
    input logic [15:0] e_ovf);
    vec_t r;
    r.v = v; r.ty = ty; r.ts = ts;
    r.pop = pop; r.clr = clr; r.ack = ack;
    r.e_rv = e_rv; r.e_ty = e_ty; r.e_ts = e_ts;
    r.e_cnt = e_cnt; r.e_irq = e_irq;
    r.e_fat = e_fat; r.e_ovf = e_ovf;
    return r;
  endfunction

  task automatic chk(input string nm,
    input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [4:0] ty,
    input logic [31:0] ts, input logic pop,
    input logic clr, input logic ack);
    error_log_valid = v;
    error_log_data  = mkd(ty, ts);
    error_timestamp = ts;
    rd_pop          = pop;
    log_clear       = clr;
    irq_ack         = ack;
    @(posedge clk);
    #1;
    error_log_valid = 1'b0;
    rd_pop          = 1'b0;
    log_clear       = 1'b0;
    irq_ack         = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_ts;

  initial begin
    rst = 1'b1;
    error_log_valid = 1'b0;
    error_log_data  = '0;
    error_timestamp = '0;
    rd_pop = 1'b0; log_clear = 1'b0; irq_ack = 1'b0;

    tv[0]  = mk(0,0,0,0,0,0,  0,0,0,0,0,0,0);
    tv[1]  = mk(1,8,32'h100,0,0,0, 1,8,32'h100,1,0,0,0);
    tv[2]  = mk(1,1,32'h101,0,0,0, 1,8,32'h100,2,1,1,0);
    tv[3]  = mk(0,0,0,0,0,1,  1,8,32'h100,2,0,0,0);
    tv[4]  = mk(0,0,0,1,0,0,  1,1,32'h101,1,0,0,0);
    tv[5]  = mk(1,3,32'h102,0,0,1, 1,1,32'h101,2,1,1,0);
    tv[6]  = mk(1,0,32'h103,1,0,0, 1,3,32'h102,2,1,1,0);
    tv[7]  = mk(1,2,32'h104,0,1,0, 0,0,0,0,0,0,0);
    tv[8]  = mk(0,0,0,1,0,0,  0,0,0,0,0,0,0);
    tv[9]  = mk(1,4,32'h200,0,0,1, 1,4,32'h200,1,0,0,0);
    tv[10] = mk(0,0,0,1,0,0,  0,0,0,0,0,0,0);

    @(posedge clk); @(posedge clk); #1;
    chk("rst_rv",  rd_valid, 0);
    chk("rst_cnt", log_count, 0);
    chk("rst_irq", log_irq, 0);
    chk("rst_data", rd_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cyc(tv[i].v, tv[i].ty, tv[i].ts,
          tv[i].pop, tv[i].clr, tv[i].ack);
      chk($sformatf("v%0d_rv", i), rd_valid, tv[i].e_rv);
      chk($sformatf("v%0d_ty", i), rd_type, tv[i].e_ty);
      chk($sformatf("v%0d_ts", i), rd_timestamp, tv[i].e_ts);
      chk($sformatf("v%0d_data", i), rd_data,
          tv[i].e_rv ? mkd(tv[i].e_ty, tv[i].e_ts) : 64'h0);
      chk($sformatf("v%0d_cnt", i), log_count, tv[i].e_cnt);
      chk($sformatf("v%0d_irq", i), log_irq, tv[i].e_irq);
      chk($sformatf("v%0d_fat", i), fatal_pending, tv[i].e_fat);
      chk($sformatf("v%0d_ovf", i), overflow_count, tv[i].e_ovf);
    end

    for (int i = 0; i < 8; i++) cyc(1, 0, 32'h300 + i, 0, 0, 0);
    chk("thr_cnt8", log_count, 8);
    chk("thr_irq8", log_irq, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("thr_cnt7", log_count, 7);
    chk("thr_irq7", log_irq, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("clr_cnt", log_count, 0);

    for (int i = 0; i < 18; i++) begin
      cyc(1, 0, i, 0, 0, 0);
      if (q.size() < 16) begin
        q.push_back(i);
      end else begin
`ifdef ERR_LOG_OVERWRITE_EN
        void'(q.pop_front());
        q.push_back(i);
`endif
      end
    end
    chk("ovf_full", log_full, 1);
    chk("ovf_cnt", log_count, 16);
    chk("ovf_ovf", overflow_count, 2);
    chk("ovf_head", rd_timestamp, q[0]);

    cyc(1, 0, 32'h100, 1, 0, 0);
    void'(q.pop_front());
    q.push_back(32'h100);
    chk("pp_cnt", log_count, 16);
    chk("pp_ovf", overflow_count, 2);

    for (int i = 0; i < 16; i++) begin
      exp_ts = q.pop_front();
      chk($sformatf("drain%0d", i), rd_timestamp, exp_ts);
      cyc(0, 0, 0, 1, 0, 0);
    end
    chk("drain_rv", rd_valid, 0);
    chk("drain_cnt", log_count, 0);

    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h500 + i, 0, 0, 0);
    chk("pre_rst_cnt", log_count, 3);
    rst = 1'b1;
    cyc(1, 1, 32'h600, 0, 0, 0);
    rst = 1'b0;
    chk("mrst_rv", rd_valid, 0);
    chk("mrst_cnt", log_count, 0);
    chk("mrst_ovf", overflow_count, 0);
    chk("mrst_fat", fatal_pending, 0);
    chk("mrst_irq", log_irq, 0);
    chk("mrst_data", rd_data, 0);
    chk("mrst_ts", rd_timestamp, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
